// File: rtl/y86_pkg.sv
// Shared Y86 decode definitions: instruction codes, special register IDs and
// the decode-stage run state.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_ESP  = 4'h4;

  typedef logic [0:0] state_t;
  localparam state_t ST_RUN  = 1'b0;
  localparam state_t ST_HALT = 1'b1;

endpackage

// File: rtl/y86_regfile.sv
// Two-read / two-write register file; reads see same-cycle writebacks,
// with the M port taking priority over the E port.
module y86_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] wval_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] wval_m
);

  localparam int AW = $clog2(NREG);

  logic [DATA_W-1:0] regs [NREG];

  function automatic logic in_range(input logic [3:0] r);
    return 32'(r) < 32'(NREG);
  endfunction

  always_comb begin
    val_a = '0;
    val_b = '0;
    if (in_range(src_a)) begin
      if (dst_m == src_a)      val_a = wval_m;
      else if (dst_e == src_a) val_a = wval_e;
      else                     val_a = regs[src_a[AW-1:0]];
    end
    if (in_range(src_b)) begin
      if (dst_m == src_b)      val_b = wval_m;
      else if (dst_e == src_b) val_b = wval_e;
      else                     val_b = regs[src_b[AW-1:0]];
    end
  end

  // M write is issued last so it wins when both ports name one register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (in_range(dst_e)) regs[dst_e[AW-1:0]] <= wval_e;
      if (in_range(dst_m)) regs[dst_m[AW-1:0]] <= wval_m;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Y86 decode stage: register source/destination decode, scoreboard-based
// hazard detection, and the registered decode-to-execute bundle.
module decode_stage import y86_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valC,
  input  logic [DATA_W-1:0] valP,
  output logic              f_stall,
  input  logic              e_stall,
  input  logic [3:0]        w_dstE,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [3:0]        w_dstM,
  input  logic [DATA_W-1:0] w_valM,
  output logic              d_valid,
  output logic [3:0]        d_icode,
  output logic [3:0]        d_ifun,
  output logic [DATA_W-1:0] d_valC,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB,
  output logic [3:0]        d_dstE,
  output logic [3:0]        d_dstM,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic              halted
);

  localparam int AW = $clog2(NREG);

  state_t            state;
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [1:0]        pending  [NREG];
  logic [1:0]        pend_nxt [NREG];
  logic [1:0]        dec      [NREG];
  logic [1:0]        inc      [NREG];
  logic [2:0]        sum      [NREG];
  logic [NREG-1:0]   busy;
  logic              hazard, issue;

  function automatic logic in_range(input logic [3:0] r);
    return 32'(r) < 32'(NREG);
  endfunction

  always_comb begin
    src_a = REG_NONE;
    src_b = REG_NONE;
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    case (icode)
      I_RRMOVL: begin src_a = rA; dst_e = rB; end
      I_IRMOVL: dst_e = rB;
      I_RMMOVL: begin src_a = rA; src_b = rB; end
      I_MRMOVL: begin src_b = rB; dst_m = rA; end
      I_OPL:    begin src_a = rA; src_b = rB; dst_e = rB; end
      I_CALL:   begin src_b = REG_ESP; dst_e = REG_ESP; end
      I_RET:    begin src_a = REG_ESP; src_b = REG_ESP; dst_e = REG_ESP; end
      I_PUSHL:  begin src_a = rA; src_b = REG_ESP; dst_e = REG_ESP; end
      I_POPL:   begin src_a = REG_ESP; src_b = REG_ESP; dst_e = REG_ESP; dst_m = rA; end
      default:  ;
    endcase
  end

  y86_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .src_a  (src_a),
    .src_b  (src_b),
    .val_a  (rd_a),
    .val_b  (rd_b),
    .dst_e  (w_dstE),
    .wval_e (w_valE),
    .dst_m  (w_dstM),
    .wval_m (w_valM)
  );

  // A register is busy only if it stays pending after this cycle's writebacks
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      dec[i] = {1'b0, w_dstE == 4'(i)} + {1'b0, w_dstM == 4'(i)};
      busy[i] = pending[i] > dec[i];
    end
  end

  assign hazard = f_valid &&
                  ((in_range(src_a) && busy[src_a[AW-1:0]]) ||
                   (in_range(src_b) && busy[src_b[AW-1:0]]));
  assign issue  = f_valid && !hazard && !e_stall && (state == ST_RUN);
  assign halted = (state == ST_HALT);
  assign f_stall = reset || e_stall || hazard || halted;

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      inc[i] = issue ? ({1'b0, dst_e == 4'(i)} + {1'b0, dst_m == 4'(i)}) : 2'd0;
      sum[i] = {1'b0, pending[i]} + {1'b0, inc[i]};
      if (sum[i] < {1'b0, dec[i]})               pend_nxt[i] = 2'd0;
      else if (sum[i] - {1'b0, dec[i]} > 3'd3)   pend_nxt[i] = 2'd3;
      else                                       pend_nxt[i] = 2'(sum[i] - {1'b0, dec[i]});
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) pending[i] <= '0;
      state <= ST_RUN;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) pending[i] <= pend_nxt[i];
      if (issue && icode == I_HALT) state <= ST_HALT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_valid <= 1'b0;
      d_icode <= '0;
      d_ifun  <= '0;
      d_valC  <= '0;
      d_valA  <= '0;
      d_valB  <= '0;
      d_dstE  <= REG_NONE;
      d_dstM  <= REG_NONE;
      d_srcA  <= REG_NONE;
      d_srcB  <= REG_NONE;
    end else if (!e_stall) begin
      d_valid <= issue;
      if (issue) begin
        d_icode <= icode;
        d_ifun  <= ifun;
        d_valC  <= valC;
        d_valA  <= (icode == I_JXX || icode == I_CALL) ? valP : rd_a;
        d_valB  <= rd_b;
        d_dstE  <= dst_e;
        d_dstM  <= dst_m;
        d_srcA  <= src_a;
        d_srcB  <= src_b;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the decode rules.
module tb_decode_stage;

  localparam int DATA_W = 32;
  localparam int NREG   = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              f_valid, e_stall;
  logic [3:0]        icode, ifun, rA, rB, w_dstE, w_dstM;
  logic [DATA_W-1:0] valC, valP, w_valE, w_valM;
  logic              f_stall, d_valid, halted;
  logic [3:0]        d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [DATA_W-1:0] d_valC, d_valA, d_valB;

  decode_stage #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clock(clock), .reset(reset), .f_valid(f_valid), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP), .f_stall(f_stall), .e_stall(e_stall),
    .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
    .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
    .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .halted(halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] mreg [NREG];
  int          mpend [NREG];
  bit          mhalt;
  logic        ev;
  logic [3:0]  eicode, eifun, edstE, edstM, esrcA, esrcB;
  logic [31:0] evalC, evalA, evalB;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit inr(input logic [3:0] r);
    return int'(r) < NREG;
  endfunction
  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction
  function automatic logic [31:0] m_read(input logic [3:0] s);
    if (!inr(s)) return 32'h0;
    if (w_dstM == s) return w_valM;
    if (w_dstE == s) return w_valE;
    return mreg[s];
  endfunction
  function automatic bit m_busy(input logic [3:0] s);
    if (!inr(s)) return 1'b0;
    return (mpend[s] - int'(w_dstE == s) - int'(w_dstM == s)) > 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin mreg[i] = '0; mpend[i] = 0; end
    mhalt = 1'b0; ev = 1'b0;
    eicode = '0; eifun = '0; evalC = '0; evalA = '0; evalB = '0;
    edstE = 4'hF; edstM = 4'hF; esrcA = 4'hF; esrcB = 4'hF;
  endtask

  task automatic drive(input logic fv, input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [31:0] vc, input logic [31:0] vp,
                       input logic es, input logic [3:0] de, input logic [31:0] ve,
                       input logic [3:0] dm, input logic [31:0] vm);
    f_valid = fv; icode = ic; ifun = 4'(ic + 4'h3); rA = ra; rB = rb; valC = vc; valP = vp;
    e_stall = es; w_dstE = de; w_valE = ve; w_dstM = dm; w_valM = vm;
  endtask

  task automatic idle(input logic [3:0] de, input logic [31:0] ve,
                      input logic [3:0] dm, input logic [31:0] vm);
    drive(1'b0, 4'h1, 4'hF, 4'hF, '0, '0, 1'b0, de, ve, dm, vm);
  endtask

  task automatic check_bundle();
    chk("d_valid", d_valid, ev);
    chk("halted", halted, mhalt);
    if (ev) begin
      chk("d_icode", d_icode, eicode);
      chk("d_ifun", d_ifun, eifun);
      chk("d_valC", d_valC, evalC);
      chk("d_valA", d_valA, evalA);
      chk("d_valB", d_valB, evalB);
      chk("d_dstE", d_dstE, edstE);
      chk("d_dstM", d_dstM, edstM);
      chk("d_srcA", d_srcA, esrcA);
      chk("d_srcB", d_srcB, esrcB);
    end
  endtask

  // One clock: check f_stall before the edge, advance the model, check the bundle.
  task automatic cycle();
    logic [3:0] sA, sB, dE, dM;
    bit haz, iss;
    logic [31:0] nA, nB;
    #2;
    sA = m_srcA(icode, rA); sB = m_srcB(icode, rB);
    dE = m_dstE(icode, rB); dM = m_dstM(icode, rA);
    haz = f_valid && (m_busy(sA) || m_busy(sB));
    iss = f_valid && !haz && !e_stall && !mhalt;
    chk("f_stall", f_stall, e_stall || haz || mhalt);
    nA = (icode == 4'h7 || icode == 4'h8) ? valP : m_read(sA);
    nB = m_read(sB);
    @(posedge clock); #1;
    for (int r = 0; r < NREG; r++) begin
      int p;
      p = mpend[r] - int'(w_dstE == 4'(r)) - int'(w_dstM == 4'(r));
      if (iss) p += int'(dE == 4'(r)) + int'(dM == 4'(r));
      mpend[r] = (p < 0) ? 0 : (p > 3) ? 3 : p;
    end
    if (inr(w_dstE)) mreg[w_dstE] = w_valE;
    if (inr(w_dstM)) mreg[w_dstM] = w_valM;
    if (!e_stall) begin
      ev = iss;
      if (iss) begin
        eicode = icode; eifun = ifun; evalC = valC; evalA = nA; evalB = nB;
        edstE = dE; edstM = dM; esrcA = sA; esrcB = sB;
      end
    end
    if (iss && icode == 4'h0) mhalt = 1'b1;
    check_bundle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_d_dstE", d_dstE, 4'hF);
    chk("rst_d_dstM", d_dstM, 4'hF);
    chk("rst_d_srcA", d_srcA, 4'hF);
    chk("rst_d_srcB", d_srcB, 4'hF);
    chk("rst_d_valA", d_valA, 32'h0);
    chk("rst_d_icode", d_icode, 4'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_f_stall", f_stall, 1'b1);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle(4'hF, '0, 4'hF, '0);
    #3;
    do_reset();

    // irmovl $0x1234, r2 then addl r1, r2 stalls until r2 is written back
    drive(1'b1, 4'h3, 4'hF, 4'h2, 32'h1234, 32'h6, 1'b0, 4'hF, '0, 4'hF, '0);
    cycle();
    chk("irmovl_dstE", d_dstE, 4'h2);
    drive(1'b1, 4'h6, 4'h1, 4'h2, '0, 32'h8, 1'b0, 4'hF, '0, 4'hF, '0);
    cycle();
    chk("addl_bubble", d_valid, 1'b0);
    #2 chk("addl_fstall", f_stall, 1'b1);
    drive(1'b1, 4'h6, 4'h1, 4'h2, '0, 32'h8, 1'b0, 4'h2, 32'h1234, 4'hF, '0);
    cycle();
    chk("addl_bypass_valB", d_valB, 32'h1234);
    drive(1'b1, 4'h2, 4'h1, 4'h2, '0, 32'h8, 1'b0, 4'h2, 32'h55, 4'hF, '0);
    cycle();

    // same-cycle E and M writes to r3: M value lands
    idle(4'h3, 32'h11, 4'h3, 32'h22);
    cycle();
    drive(1'b1, 4'h4, 4'h3, 4'h1, '0, 32'h10, 1'b0, 4'hF, '0, 4'hF, '0);
    cycle();
    chk("r3_m_wins", d_valA, 32'h22);

    // call with ESP = 0x100
    idle(4'h4, 32'h100, 4'h2, 32'h9);
    cycle();
    drive(1'b1, 4'h8, 4'hF, 4'hF, 32'h77, 32'h40, 1'b0, 4'hF, '0, 4'hF, '0);
    cycle();
    chk("call_valA", d_valA, 32'h40);
    chk("call_valB", d_valB, 32'h100);
    chk("call_dstE", d_dstE, 4'h4);
    chk("call_dstM", d_dstM, 4'hF);
    idle(4'h4, 32'h0FC, 4'hF, '0);
    cycle();

    // popl r5 then execute stalls for three cycles
    drive(1'b1, 4'hB, 4'h5, 4'hF, '0, 32'h50, 1'b0, 4'hF, '0, 4'hF, '0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'h6, 4'h0, 4'h1, '0, 32'h52, 1'b1, 4'hF, '0, 4'hF, '0);
      cycle();
      chk("popl_hold_dstM", d_dstM, 4'h5);
      chk("popl_hold_srcA", d_srcA, 4'h4);
      chk("popl_hold_valid", d_valid, 1'b1);
    end
    idle(4'h4, 32'h100, 4'h5, 32'hAB);
    cycle();

    // random traffic with occasional asynchronous reset
    for (int n = 0; n < 400; n++) begin
      logic [3:0] rr[4];
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 9))
          0:       rr[j] = 4'hF;
          1:       rr[j] = 4'($urandom_range(8, 14));
          default: rr[j] = 4'($urandom_range(0, NREG - 1));
        endcase
      end
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(1, 11)), rr[0], rr[1],
            $urandom, $urandom, $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) ? rr[2] : 4'hF, $urandom,
            $urandom_range(0, 2) == 0 ? rr[3] : 4'hF, $urandom);
      if ($urandom_range(0, 59) == 0) do_reset();
      else cycle();
    end

    // halt: later fetches ignored, writebacks still land, reset recovers
    idle(4'hF, '0, 4'hF, '0);
    do_reset();
    drive(1'b1, 4'h0, 4'hF, 4'hF, '0, 32'h90, 1'b0, 4'hF, '0, 4'hF, '0);
    cycle();
    chk("halt_halted", halted, 1'b1);
    drive(1'b1, 4'h1, 4'hF, 4'hF, '0, 32'h91, 1'b0, 4'h6, 32'h77, 4'hF, '0);
    cycle();
    chk("halt_no_issue", d_valid, 1'b0);
    #2 chk("halt_fstall", f_stall, 1'b1);
    drive(1'b1, 4'h2, 4'h6, 4'h1, '0, 32'h92, 1'b0, 4'hF, '0, 4'hF, '0);
    cycle();
    do_reset();
    drive(1'b1, 4'h2, 4'h6, 4'h1, '0, 32'h92, 1'b0, 4'hF, '0, 4'hF, '0);
    cycle();
    chk("post_reset_r6", d_valA, 32'h0);
    chk("post_reset_run", d_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1);
  end

endmodule
